// File: rtl/fifo_rd_stream.sv
// Read stage that drains fifo_flops into a valid/ready stream, with a main + skid buffer.
// Optional WORD_CNT_EN adds out_count, a wrapping count of accepted transfers.
//
// state | meaning
// EMPTY | no word buffered, out_valid low
// ONE   | one word in main
// TWO   | main and skid both hold words, older word in main
module fifo_rd_stream #(
    parameter int bits  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [bits-1:0]  fifo_Dout,
    input  logic             fifo_pndng,
    output logic             fifo_pop,
    input  logic             flush,
    output logic [bits-1:0]  out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef WORD_CNT_EN
    ,
    output logic [CNT_W-1:0] out_count
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [bits-1:0] main_q;
    logic [bits-1:0] skid_q;
    logic            acc;
    logic            ld_main_fifo;
    logic            ld_main_skid;
    logic            ld_skid;

    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign acc       = out_valid & out_ready;

    // Only a full buffer facing a stalled sink has nowhere to put a new word.
    assign fifo_pop  = fifo_pndng & ~rst & ~flush & ~((state == TWO) & ~out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ld_main_fifo = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (fifo_pop) begin
                        state_nxt    = ONE;
                        ld_main_fifo = 1'b1;
                    end
                end
                ONE: begin
                    if (fifo_pop && acc) begin
                        ld_main_fifo = 1'b1;
                    end else if (fifo_pop) begin
                        state_nxt = TWO;
                        ld_skid   = 1'b1;
                    end else if (acc) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (acc) begin
                        ld_main_skid = 1'b1;
                        if (fifo_pop) begin
                            ld_skid = 1'b1;
                        end else begin
                            state_nxt = ONE;
                        end
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (ld_main_fifo) begin
                main_q <= fifo_Dout;
            end else if (ld_main_skid) begin
                main_q <= skid_q;
            end
            if (ld_skid) begin
                skid_q <= fifo_Dout;
            end
        end
    end

`ifdef WORD_CNT_EN
    // A handshake in the same cycle as flush still counts; flush never clears the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_count <= '0;
        end else if (acc) begin
            out_count <= out_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: the FIFO is a bench queue and the output buffer is modelled as a
// queue of at most two words; directed phases follow the test plan, then a randomized phase.
module tb_fifo_rd_stream;
    localparam int BITS = 32;
    localparam int CW   = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [BITS-1:0] fifo_Dout = '0;
    logic            fifo_pndng = 1'b0;
    logic            flush = 1'b0;
    logic            out_ready = 1'b0;
    wire             fifo_pop;
    wire             out_valid;
    wire  [BITS-1:0] out_data;
`ifdef WORD_CNT_EN
    wire  [CW-1:0]   out_count;
`endif

    always #5 clk = ~clk;

    fifo_rd_stream #(.bits(BITS), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .fifo_Dout(fifo_Dout),
        .fifo_pndng(fifo_pndng),
        .fifo_pop(fifo_pop),
        .flush(flush),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef WORD_CNT_EN
        ,
        .out_count(out_count)
`endif
    );

    int              total = 0;
    int              bad = 0;
    logic [BITS-1:0] fq[$];
    logic [BITS-1:0] mq[$];
    logic [BITS-1:0] got[$];
    int              cnt_m = 0;
    int              to_push = 0;
    int              push_pct = 0;
    logic [BITS-1:0] src_next = '0;
    int              pops_seen = 0;
    logic [BITS-1:0] last_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input bit rdy, input bit fl);
        bit ep;
        bit acc;
        out_ready  = rdy;
        flush      = fl;
        fifo_pndng = (fq.size() > 0);
        fifo_Dout  = (fq.size() > 0) ? fq[0] : '0;
        #1;
        ep  = (fq.size() > 0) && !fl && !(mq.size() == 2 && !rdy);
        acc = (mq.size() > 0) && rdy;
        chk("out_valid", out_valid, mq.size() > 0);
        if (mq.size() > 0) chk("out_data", out_data, mq[0]);
        chk("fifo_pop", fifo_pop, ep);
`ifdef WORD_CNT_EN
        chk("out_count", out_count, cnt_m % (1 << CW));
`endif
        if (fifo_pop) pops_seen++;
        last_data = out_data;
        @(posedge clk);
        if (acc) begin
            got.push_back(mq.pop_front());
            cnt_m++;
        end
        if (fl) mq.delete();
        else if (ep) mq.push_back(fq.pop_front());
        if (to_push > 0 && fq.size() < 16 && $urandom_range(0, 99) < push_pct) begin
            fq.push_back(src_next);
            src_next++;
            to_push--;
        end
        @(negedge clk);
    endtask

    task automatic reset_seq(input int n);
        rst = 1'b1;
        #1;
        chk("rst_valid_async", out_valid, 0);
        chk("rst_data_async", out_data, 0);
        chk("rst_pop_async", fifo_pop, 0);
        mq.delete();
        cnt_m = 0;
        repeat (n) begin
            fifo_pndng = (fq.size() > 0);
            fifo_Dout  = (fq.size() > 0) ? fq[0] : '0;
            #1;
            chk("rst_pop", fifo_pop, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_data", out_data, 0);
`ifdef WORD_CNT_EN
            chk("rst_count", out_count, 0);
`endif
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    initial begin
        int p0;
        logic [BITS-1:0] stall_data;

        // Reset with a loaded FIFO, then streaming 0..15
        for (int i = 0; i < 16; i++) fq.push_back(BITS'(i));
        @(negedge clk);
        reset_seq(3);
        step(1'b1, 1'b0);
        chk("first_release_valid", out_valid, 1);
        chk("first_release_data", out_data, 0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0);
            chk("stream_no_gap", got.size(), i + 1);
        end
        chk("drain_valid", out_valid, 0);
        for (int i = 0; i < 16; i++) chk("stream_word", got[i], i);

        // Back-pressure mid-stream
        got.delete();
        for (int i = 0; i < 16; i++) fq.push_back(BITS'(100 + i));
        repeat (4) step(1'b1, 1'b0);
        pops_seen = 0;
        step(1'b0, 1'b0);
        stall_data = last_data;
        repeat (4) begin
            step(1'b0, 1'b0);
            chk("stall_data_stable", last_data, stall_data);
        end
        chk("stall_extra_pops", pops_seen, 1);
        repeat (20) step(1'b1, 1'b0);
        chk("bp_count", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++) chk("bp_word", got[i], 100 + i);

        // Full FIFO behind a stalled sink
        got.delete();
        src_next = BITS'(200);
        to_push  = 18;
        push_pct = 100;
        repeat (20) step(1'b0, 1'b0);
        chk("fifo_full", fq.size(), 16);
        chk("full_valid", out_valid, 1);
        repeat (25) step(1'b1, 1'b0);
        chk("full_count", got.size(), 18);
        for (int i = 0; i < 18 && i < got.size(); i++) chk("full_word", got[i], 200 + i);

        // Flush with words 7 and 8 buffered
        reset_seq(2);
        for (int i = 7; i <= 12; i++) fq.push_back(BITS'(i));
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("pre_flush_data", out_data, 7);
`ifdef WORD_CNT_EN
        chk("pre_flush_count", out_count, 0);
`endif
        p0 = pops_seen;
        step(1'b0, 1'b1);
        chk("flush_pop", pops_seen - p0, 0);
        chk("flush_valid", out_valid, 0);
        got.delete();
        repeat (8) step(1'b1, 1'b0);
        chk("after_flush_count", got.size(), 4);
        if (got.size() > 0) chk("after_flush_word", got[0], 9);

`ifdef WORD_CNT_EN
        // Twenty transfers through a 4-bit counter
        reset_seq(2);
        fq.delete();
        src_next = BITS'(300);
        to_push  = 20;
        push_pct = 100;
        repeat (25) step(1'b1, 1'b0);
        chk("cnt_wrap", out_count, 4);
        step(1'b1, 1'b1);
        chk("cnt_flush", out_count, 4);
        reset_seq(1);
        chk("cnt_rst", out_count, 0);
`endif

        // Randomized traffic with occasional mid-run resets
        got.delete();
        fq.delete();
        reset_seq(2);
        src_next = BITS'(1000);
        to_push  = 100000;
        for (int i = 0; i < 2000; i++) begin
            if (i % 200 == 0) push_pct = $urandom_range(20, 100);
            if (i % 500 == 499) begin
                fq.delete();
                reset_seq(2);
            end
            step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
